// File: rtl/stepgen_ramp_ctrl.sv
// stepgen_ramp_ctrl
//   Acceleration/deceleration sequencer feeding one stepgen's jointFreqCmd.
//   Ramps a signed half-period command (sign = direction, magnitude = period
//   in clk cycles, 0 = stop) toward a target in bounded steps. A reversal
//   always passes through DECEL and at least one IDLE cycle. E-stop forces
//   an immediate zero.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   enable       motion permitted
//   estop        level-sensitive emergency stop, overrides everything
//   target_cmd   requested period command, two's complement
//   freq_cmd     registered period command, two's complement
//   busy         registered: state was not IDLE
//   at_target    registered: RUN and period equals the clamped target
//
// All three outputs are registered from the current state/cur/dir, so they
// follow a state or cur change by one clock.
module stepgen_ramp_ctrl #(
    parameter int WIDTH        = 32,
    parameter int UPDATE_DIV   = 1000,
    parameter int RAMP_STEP    = 16,
    parameter int START_PERIOD = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             estop,
    input  logic [WIDTH-1:0] target_cmd,
    output logic [WIDTH-1:0] freq_cmd,
    output logic             busy,
    output logic             at_target
);

    localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(UPDATE_DIV - 1);
    localparam logic [WIDTH-1:0] START    = WIDTH'(START_PERIOD);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RUN, DECEL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] freq_q, freq_d;
    logic             busy_q, busy_d;
    logic             at_q, at_d;

    logic             tick;
    logic [WIDTH-1:0] abs_tgt, t_mag;
    logic             tgt_nz, tgt_fwd, go, same_dir;

    // Free-running prescaler, independent of the state machine.
    always_comb begin
        tick  = (cnt_q == DIV_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Most-negative target negates to itself, i.e. 2^(WIDTH-1) unsigned,
    // which the clamp then limits to START.
    always_comb begin
        abs_tgt  = target_cmd[WIDTH-1] ? (~target_cmd) + WIDTH'(1) : target_cmd;
        t_mag    = (abs_tgt > START) ? START : abs_tgt;
        tgt_nz   = |target_cmd;
        tgt_fwd  = ~target_cmd[WIDTH-1];
        go       = enable & tgt_nz;
        same_dir = (tgt_fwd == dir_q);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dir_d   = dir_q;
        if (estop) begin
            state_d = IDLE;
            cur_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        dir_d   = tgt_fwd;
                        cur_d   = START;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Stop condition is evaluated every cycle and beats a tick.
                    if (!go || !same_dir) begin
                        state_d = DECEL;
                    end else if (tick) begin
                        // Compare the gap against STEP so nothing can wrap.
                        if (cur_q > t_mag)
                            cur_d = (cur_q - t_mag > STEP) ? cur_q - STEP : t_mag;
                        else if (cur_q < t_mag)
                            cur_d = (t_mag - cur_q > STEP) ? cur_q + STEP : t_mag;
                    end
                end
                DECEL: begin
                    if (go && same_dir) begin
                        state_d = RUN;
                    end else if (tick) begin
                        if (cur_q == START) begin
                            state_d = IDLE;
                            cur_d   = '0;
                        end else begin
                            cur_d = (START - cur_q > STEP) ? cur_q + STEP : START;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cur_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        freq_d = '0;
        if (state_q != IDLE)
            freq_d = dir_q ? cur_q : (~cur_q) + WIDTH'(1);
        busy_d = (state_q != IDLE);
        at_d   = (state_q == RUN) && (cur_q == t_mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            freq_q  <= '0;
            busy_q  <= 1'b0;
            at_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            busy_q  <= busy_d;
            at_q    <= at_d;
        end
    end

    assign freq_cmd  = freq_q;
    assign busy      = busy_q;
    assign at_target = at_q;

endmodule
